// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding,
// address-limit helper and the read-return latency.
package data_mem_arbiter_pkg;

  // Which requester owns a grant or an in-flight read.
  typedef enum logic {
    OWN_M0 = 1'b0,  // matrix-multiply core
    OWN_M1 = 1'b1   // host loader/dump engine
  } owner_e;

  // Cycles from a read grant to its rvalid pulse.
  localparam int RD_LATENCY = 2;

  // Highest byte address; a 16-bit write there would spill past the top.
  function automatic int addr_limit(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

  localparam int ADDR_LIMIT = addr_limit(8);

endpackage

// File: rtl/data_mem_arbiter_grant.sv
// rr_grant_2: two-way round-robin grant with a bounded burst lock.
// A locked owner keeps winning contested cycles until burst_cnt hits
// MAX_BURST; after that the waiting side is served.
module rr_grant_2 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  import data_mem_arbiter_pkg::*;

  localparam int CW = $clog2(MAX_BURST + 1);

  owner_e        last_owner;
  logic          last_lock;
  logic [CW-1:0] burst_cnt;
  owner_e        pick;
  logic          any_gnt;

  // Choose the winner for this cycle; no grant while reset is asserted.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    gnt     = 2'b00;
    pick    = last_owner;
    any_gnt = 1'b0;
    unique case (req)
      2'b01: begin
        pick    = OWN_M0;
        any_gnt = 1'b1;
      end
      2'b10: begin
        pick    = OWN_M1;
        any_gnt = 1'b1;
      end
      2'b11: begin
        any_gnt = 1'b1;
        if (last_lock && (burst_cnt < CW'(MAX_BURST))) pick = last_owner;
        else                                          pick = owner_e'(~last_owner);
      end
      default: any_gnt = 1'b0;
    endcase
    if (any_gnt && rst_n) gnt[pick] = 1'b1;
  end

  // Track the previous owner, its lock request and the current burst length.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is assigned with <= so every flop samples the pre-edge values of its neighbours.
    if (!rst_n) begin
      last_owner <= OWN_M1;
      last_lock  <= 1'b0;
      burst_cnt  <= '0;
    end else if (any_gnt) begin
      last_owner <= pick;
      last_lock  <= lock[pick];
      if (pick == last_owner) begin
        if (burst_cnt != CW'(MAX_BURST)) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        burst_cnt <= CW'(1);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of the data memory. Registers the winning
// command, blocks writes that would run past the top address, and returns
// read bytes to the requester that issued them two cycles after the grant.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req,
  input  logic                    m0_lock,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [2*DATA_WIDTH-1:0] m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_lock,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [2*DATA_WIDTH-1:0] m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_err,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);
  import data_mem_arbiter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(addr_limit(ADDR_WIDTH));

  logic [1:0]              gnt;
  logic                    cmd_valid;
  owner_e                  sel_owner;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [2*DATA_WIDTH-1:0] sel_wdata;
  logic                    bad_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [1:0]              err_q;
  logic [RD_LATENCY-1:0]   rd_vld;
  owner_e                  rd_own [RD_LATENCY];

  rr_grant_2 #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .lock  ({m1_lock, m0_lock}),
    .gnt   (gnt)
  );

  assign m0_gnt    = gnt[OWN_M0];
  assign m1_gnt    = gnt[OWN_M1];
  assign cmd_valid = |gnt;

  // Steer the granted requester's command onto the shared command bus.
  always_comb begin
    sel_owner = OWN_M0;
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (gnt[OWN_M1]) begin
      sel_owner = OWN_M1;
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // The high byte of a write at the top address has nowhere to go.
  assign bad_write = sel_we && (sel_addr == ADDR_MAX);

  // Command register: memory sees the granted command one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      cmd_addr   <= '0;
      mem_w_data <= '0;
    end else begin
      mem_we <= cmd_valid && sel_we && !bad_write;
      if (cmd_valid) begin
        cmd_addr   <= sel_addr;
        mem_w_data <= sel_wdata;
      end
    end
  end

  assign mem_w_addr = cmd_addr;
  assign mem_r_addr = cmd_addr;

  // Rejected-write pulse, aligned with the cycle the write would have executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= bad_write ? gnt : 2'b00;
  end

  assign m0_err = err_q[OWN_M0];
  assign m1_err = err_q[OWN_M1];

  // Owner/valid pipeline that follows each read until its byte returns.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these few tracking flops are reset so reads in flight at reset never produce a stale rvalid.
    if (!rst_n) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_own[i] <= OWN_M0;
    end else begin
      rd_vld[0] <= cmd_valid && !sel_we;
      rd_own[0] <= sel_owner;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_own[i] <= rd_own[i-1];
      end
    end
  end

  assign m0_rvalid = rd_vld[RD_LATENCY-1] && (rd_own[RD_LATENCY-1] == OWN_M0);
  assign m1_rvalid = rd_vld[RD_LATENCY-1] && (rd_own[RD_LATENCY-1] == OWN_M1);
  assign m0_rdata  = mem_r_data;
  assign m1_rdata  = mem_r_data;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256-byte memory
// (registered read, 16-bit write to addr/addr+1).
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_lock, m0_we;
  logic [7:0]  m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [7:0]  m0_rdata;
  logic        m1_req, m1_lock, m1_we;
  logic [7:0]  m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [7:0]  m1_rdata;
  logic        mem_we;
  logic [7:0]  mem_w_addr, mem_r_addr;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_r_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic       mem_load;

  data_mem_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_lock    (m0_lock),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_lock    (m1_lock),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .m1_err     (m1_err),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0:       return 8'h02;
      2:       return 8'h03;
      4:       return 8'h02;
      default: return 8'((i * 7) + 1);
    endcase
  endfunction

  // Memory model: preload, then write pair or registered read each cycle.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_r_data <= 8'h00;
    end else if (mem_we) begin
      mem[mem_w_addr]         <= mem_w_data[7:0];
      mem[mem_w_addr + 8'd1]  <= mem_w_data[15:8];
    end else begin
      mem_r_data <= mem[mem_r_addr];
    end
  end

  task automatic drive_m0(input logic req, input logic lock, input logic we,
                          input logic [7:0] addr, input logic [15:0] wdata);
    m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic lock, input logic we,
                          input logic [7:0] addr, input logic [15:0] wdata);
    m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    drive_m0(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    drive_m1(1'b1, 1'b0, 1'b1, 8'h20, 16'h1234);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt});
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we);
    end
    checks++;
    if ({mem_w_addr, mem_r_addr, mem_w_data} !== 32'h0) begin
      errors++; $display("FAIL reset_mem_cmd: got %h expected 0", {mem_w_addr, mem_r_addr, mem_w_data});
    end
    checks++;
    if ({m1_rvalid, m0_rvalid, m1_err, m0_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {m1_rvalid, m0_rvalid, m1_err, m0_err});
    end
    idle_all();
  endtask

  task automatic test_single_read();
    do_reset();
    drive_m0(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL single_gnt: got %b expected 01", {m1_gnt, m0_gnt});
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00 || mem_r_addr !== 8'h00) begin
      errors++; $display("FAIL single_c1: rvalid %b addr %h expected 00 00", {m1_rvalid, m0_rvalid}, mem_r_addr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b01) begin
      errors++; $display("FAIL single_rvalid: got %b expected 01", {m1_rvalid, m0_rvalid});
    end
    checks++;
    if (m0_rdata !== 8'h02) begin
      errors++; $display("FAIL single_rdata: got %h expected 02", m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL single_pulse: got %b expected 00", {m1_rvalid, m0_rvalid});
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g, exp_v;
    logic [7:0] exp_d, got_d;
    do_reset();
    drive_m0(1'b1, 1'b0, 1'b0, 8'd2, 16'h0000);
    drive_m1(1'b1, 1'b0, 1'b0, 8'd4, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) idle_all();
      @(negedge clk);
      if (k < 6) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if ({m1_gnt, m0_gnt} !== exp_g) begin
          errors++; $display("FAIL alt_gnt[%0d]: got %b expected %b", k, {m1_gnt, m0_gnt}, exp_g);
        end
      end
      if (k >= 2) begin
        exp_v = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = exp_v[0] ? 8'h03 : 8'h02;
        got_d = exp_v[0] ? m0_rdata : m1_rdata;
        checks++;
        if ({m1_rvalid, m0_rvalid} !== exp_v || got_d !== exp_d) begin
          errors++; $display("FAIL alt_ret[%0d]: rvalid %b data %h expected %b %h",
                             k, {m1_rvalid, m0_rvalid}, got_d, exp_v, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    drive_m1(1'b1, 1'b0, 1'b1, 8'd40, 16'hBEEF);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      errors++; $display("FAIL wr_gnt: got %b expected 10", {m1_gnt, m0_gnt});
    end
    next_cycle();
    idle_all();
    drive_m0(1'b1, 1'b0, 1'b0, 8'd40, 16'h0000);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_w_addr !== 8'd40 || mem_w_data !== 16'hBEEF) begin
      errors++; $display("FAIL wr_cmd: gnt %b we %b addr %h data %h expected 1 1 28 beef",
                         m0_gnt, mem_we, mem_w_addr, mem_w_data);
    end
    next_cycle();
    drive_m0(1'b1, 1'b0, 1'b0, 8'd41, 16'h0000);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rd41_gnt: gnt %b we %b expected 1 0", m0_gnt, mem_we);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'hEF) begin
      errors++; $display("FAIL raw_lo: rvalid %b data %h expected 1 ef", m0_rvalid, m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'hBE) begin
      errors++; $display("FAIL raw_hi: rvalid %b data %h expected 1 be", m0_rvalid, m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL raw_end: got %b expected 00", {m1_rvalid, m0_rvalid});
    end
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 8'd2, 16'h0000);
    drive_m1(1'b1, 1'b0, 1'b0, 8'd4, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_seq[k]) begin
        errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", k, {m1_gnt, m0_gnt}, exp_seq[k]);
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_bad_write();
    do_reset();
    drive_m0(1'b1, 1'b0, 1'b1, 8'd255, 16'h1234);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL top_gnt: got %b expected 1", m0_gnt);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL top_we: got %b expected 0", mem_we);
    end
    checks++;
    if ({m1_err, m0_err} !== 2'b01) begin
      errors++; $display("FAIL top_err: got %b expected 01", {m1_err, m0_err});
    end
    next_cycle();
    drive_m0(1'b1, 1'b0, 1'b0, 8'd0, 16'h0000);
    @(negedge clk);
    checks++;
    if ({m1_err, m0_err} !== 2'b00 || mem_we !== 1'b0) begin
      errors++; $display("FAIL top_err_end: err %b we %b expected 00 0", {m1_err, m0_err}, mem_we);
    end
    next_cycle();
    idle_all();
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h02) begin
      errors++; $display("FAIL top_nowrap: rvalid %b data %h expected 1 02", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m0(1'b1, 1'b0, 1'b0, 8'd2, 16'h0000);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got %b expected 1", m0_gnt);
    end
    next_cycle();
    idle_all();
    drive_m1(1'b1, 1'b0, 1'b0, 8'd4, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_gnt: got %b expected 00", {m1_gnt, m0_gnt});
    end
    next_cycle();
    idle_all();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
        errors++; $display("FAIL mid_stale[%0d]: got %b expected 00", k, {m1_rvalid, m0_rvalid});
      end
      next_cycle();
    end
    drive_m0(1'b1, 1'b0, 1'b0, 8'd2, 16'h0000);
    drive_m1(1'b1, 1'b0, 1'b0, 8'd4, 16'h0000);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL mid_first: got %b expected 01", {m1_gnt, m0_gnt});
    end
    next_cycle();
    idle_all();
  endtask

  initial begin
    mem_load = 1'b1;
    rst_n    = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
    mem_load = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_bad_write();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
